deskew_ctrl: RTL and testbench

Sequencer and memory-port arbiter for the deskew engine. It owns the shared 1568-word image BRAM (raw image at words 0–783, deskewed image at words 784–1567) and grants the port to the host loader while idle and to the engine while a deskew runs. It launches the engine, detects its completion, reports a run-time cycle count, and signals the downstream SVM classifier that the deskewed image is ready.

---
 rtl/deskew_pkg.sv | 28 ++
 rtl/deskew_if.sv | 14 +
 rtl/deskew_mem_mux.sv | 44 ++++
 rtl/deskew_ctrl.sv | 151 +++++++++++++++
 tb/tb_deskew_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deskew_pkg.sv
// Shared types and image geometry for the deskew sequencer and its memory-port mux.
// COPY_* states exist only when DESKEW_BYPASS_EN is defined.
package deskew_pkg;

  localparam int IMG_DIM    = 28;
  localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
  localparam int OUT_BASE   = IMG_PIXELS;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    RUN,
    DONE
`ifdef DESKEW_BYPASS_EN
    ,
    COPY_RD,
    COPY_WR
`endif
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOST,
    SEL_ENG,
    SEL_CTRL
  } mux_sel_e;

endpackage

// File: rtl/deskew_if.sv
// Single-port BRAM access bundle: strobes, address and write data one way, read data back.
interface deskew_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/deskew_mem_mux.sv
// Combinational three-way BRAM port selector (host, engine, controller copy path).
// Read data fans out to both requesters unconditionally.
module deskew_mem_mux
  import deskew_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
) (
  input  mux_sel_e          sel,
  deskew_if.slave           host,
  deskew_if.slave           eng,
  input  logic              ctrl_en,
  input  logic              ctrl_we,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [WIDTH-1:0]  ctrl_wdata,
  deskew_if.master          mem
);

  always_comb begin
    mem.en    = host.en;
    mem.we    = host.we;
    mem.addr  = host.addr;
    mem.wdata = host.wdata;
    case (sel)
      SEL_ENG: begin
        mem.en    = eng.en;
        mem.we    = eng.we;
        mem.addr  = eng.addr;
        mem.wdata = eng.wdata;
      end
      SEL_CTRL: begin
        mem.en    = ctrl_en;
        mem.we    = ctrl_we;
        mem.addr  = ctrl_addr;
        mem.wdata = ctrl_wdata;
      end
      default: ;
    endcase
  end

  assign host.rdata = mem.rdata;
  assign eng.rdata  = mem.rdata;

endmodule

// File: rtl/deskew_ctrl.sv
// Deskew run sequencer: launches the engine, arbitrates the shared image BRAM, times each run.
// Optional feature macro DESKEW_BYPASS_EN adds a raw-to-output copy path selected by host_bypass.
module deskew_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 11,
  parameter int IMG_PIXELS = deskew_pkg::IMG_PIXELS,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_start,
`ifdef DESKEW_BYPASS_EN
  input  logic             host_bypass,
`endif
  output logic             host_busy,
  output logic             host_done,
  output logic             host_overrun,
  output logic             host_grant,
  output logic [CNT_W-1:0] run_cycles,
  output logic             eng_start,
  input  logic             eng_ready,
  deskew_if.slave          host_mem,
  deskew_if.slave          eng_mem,
  deskew_if.master         mem
);
  import deskew_pkg::*;

  state_e            state_reg, state_next;
  mux_sel_e          sel;
  logic [CNT_W-1:0]  cnt_reg;
  logic              counting;
  logic              ctrl_en, ctrl_we;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [WIDTH-1:0]  ctrl_wdata;

`ifdef DESKEW_BYPASS_EN
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0] OUT_OFS  = ADDR_W'(IMG_PIXELS);
  logic [ADDR_W-1:0] pix_reg;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    eng_start  = 1'b0;
    sel        = SEL_HOST;
    counting   = 1'b0;
    case (state_reg)
      IDLE: begin
`ifdef DESKEW_BYPASS_EN
        if (host_start) state_next = host_bypass ? COPY_RD : START;
`else
        if (host_start) state_next = START;
`endif
      end
      START: begin
        sel        = SEL_ENG;
        eng_start  = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Keep knocking until the engine drops ready to acknowledge the launch.
        sel      = SEL_ENG;
        counting = 1'b1;
        if (eng_ready) eng_start  = 1'b1;
        else           state_next = RUN;
      end
      RUN: begin
        sel      = SEL_ENG;
        counting = 1'b1;
        if (eng_ready) state_next = DONE;
      end
      DONE: state_next = IDLE;
`ifdef DESKEW_BYPASS_EN
      COPY_RD: begin
        sel        = SEL_CTRL;
        counting   = 1'b1;
        state_next = COPY_WR;
      end
      COPY_WR: begin
        sel        = SEL_CTRL;
        counting   = 1'b1;
        state_next = (pix_reg == LAST_PIX) ? DONE : COPY_RD;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign host_busy    = (state_reg != IDLE);
  assign host_done    = (state_reg == DONE);
  assign host_overrun = host_busy & host_start;
  assign host_grant   = (sel == SEL_HOST);

  // Holding the counter at zero through IDLE makes every run start from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      run_cycles <= '0;
    end else begin
      if (state_reg == IDLE)
        cnt_reg <= '0;
      else if (counting && (cnt_reg != '1))
        cnt_reg <= cnt_reg + CNT_W'(1);
      if (state_reg == DONE)
        run_cycles <= cnt_reg;
    end
  end

`ifdef DESKEW_BYPASS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    pix_reg <= '0;
    else if (state_reg == IDLE)    pix_reg <= '0;
    else if (state_reg == COPY_WR) pix_reg <= pix_reg + ADDR_W'(1);
  end

  // Read pixel i, then write the word that arrives a cycle later into the output region.
  always_comb begin
    ctrl_en    = (state_reg == COPY_RD) || (state_reg == COPY_WR);
    ctrl_we    = (state_reg == COPY_WR);
    ctrl_addr  = (state_reg == COPY_WR) ? (pix_reg + OUT_OFS) : pix_reg;
    ctrl_wdata = mem.rdata;
  end
`else
  always_comb begin
    ctrl_en    = 1'b0;
    ctrl_we    = 1'b0;
    ctrl_addr  = '0;
    ctrl_wdata = '0;
  end
`endif

  deskew_mem_mux #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem_mux (
    .sel        (sel),
    .host       (host_mem),
    .eng        (eng_mem),
    .ctrl_en    (ctrl_en),
    .ctrl_we    (ctrl_we),
    .ctrl_addr  (ctrl_addr),
    .ctrl_wdata (ctrl_wdata),
    .mem        (mem)
  );

endmodule

// File: tb/tb_deskew_ctrl.sv
// Self-checking bench for deskew_ctrl: table-driven runs, randomized runs and memory traffic,
// plus hand sequences for arbitration, reset and (with DESKEW_BYPASS_EN) the copy path.
module tb_deskew_ctrl;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 24;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             host_start = 1'b0;
`ifdef DESKEW_BYPASS_EN
  logic             host_bypass = 1'b0;
`endif
  logic             host_busy, host_done, host_overrun, host_grant;
  logic [CNT_W-1:0] run_cycles;
  logic             eng_start;
  logic             eng_ready;

  deskew_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) host_if ();
  deskew_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) eng_if ();
  deskew_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) mem_if ();

  deskew_ctrl #(
    .WIDTH      (WIDTH),
    .ADDR_W     (ADDR_W),
    .IMG_PIXELS (784),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_start   (host_start),
`ifdef DESKEW_BYPASS_EN
    .host_bypass  (host_bypass),
`endif
    .host_busy    (host_busy),
    .host_done    (host_done),
    .host_overrun (host_overrun),
    .host_grant   (host_grant),
    .run_cycles   (run_cycles),
    .eng_start    (eng_start),
    .eng_ready    (eng_ready),
    .host_mem     (host_if),
    .eng_mem      (eng_if),
    .mem          (mem_if)
  );

  // BRAM model: one port, read-first, 1-cycle read latency
  logic [WIDTH-1:0] bram [0:2047];
  always @(posedge clk) begin
    if (mem_if.en) begin
      if (mem_if.we) bram[mem_if.addr] <= mem_if.wdata;
      mem_if.rdata <= bram[mem_if.addr];
    end
  end

  // Engine model: ignores the first cfg_k launches, then stays busy for cfg_b cycles
  int cfg_k = 0;
  int cfg_b = 1;
  int ign_cnt;
  int busy_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_ready <= 1'b1;
      ign_cnt   <= 0;
      busy_cnt  <= 0;
    end else if (eng_ready) begin
      if (eng_start) begin
        if (ign_cnt < cfg_k) ign_cnt <= ign_cnt + 1;
        else begin
          ign_cnt   <= 0;
          eng_ready <= 1'b0;
          busy_cnt  <= cfg_b;
        end
      end
    end else begin
      if (busy_cnt <= 1) eng_ready <= 1'b1;
      else               busy_cnt  <= busy_cnt - 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    host_if.en = 1'b1; host_if.we = 1'b1; host_if.addr = a; host_if.wdata = d;
    @(negedge clk);
    host_if.en = 1'b0; host_if.we = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, output logic [WIDTH-1:0] d);
    @(negedge clk);
    host_if.en = 1'b1; host_if.we = 1'b0; host_if.addr = a;
    @(negedge clk);
    host_if.en = 1'b0;
    d = host_if.rdata;
  endtask

  // Reference timing from the protocol: launch at edge n, k refused launches, b busy cycles.
  // START n+1, engine idle again at m = n+2+k+b, DONE at m+1, run_cycles = m-n-1.
  function automatic void model(input int k, input int b, input int inj,
                                output int starts, output int done_at,
                                output int cycles, output int ovrs);
    starts  = k + 1;
    done_at = 3 + k + b;
    cycles  = 1 + k + b;
    ovrs    = (inj != 0) ? 1 : 0;
  endfunction

  // One run: host_start at edge n, then observe each cycle (e = cycles after n) at the negedge.
  task automatic run_one(input int k, input int b, input int inj,
                         output int starts, output int done_at, output int dones,
                         output int ovrs, output int grants);
    cfg_k = k; cfg_b = b;
    starts = 0; done_at = -1; dones = 0; ovrs = 0; grants = 0;
    @(negedge clk);
    host_start = 1'b1;
    @(posedge clk);
    #1 host_start = 1'b0;
    for (int e = 1; e <= 4000; e++) begin
      @(negedge clk);
      host_start = (e == inj);
      #1;
      if (eng_start)    starts++;
      if (host_overrun) ovrs++;
      if (host_done) begin
        dones++;
        if (done_at < 0) done_at = e;
      end
      if (done_at < 0 && host_grant) grants++;
      if (done_at >= 0 && e >= done_at + 4) break;
    end
    host_start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int k, input int b, input int inj,
                           input int es, input int ed, input int ec, input int eo);
    int s, d, n, o, g;
    run_one(k, b, inj, s, d, n, o, g);
    $display("run %s k=%0d b=%0d inj=%0d: starts=%0d done_at=%0d dones=%0d ovr=%0d run_cycles=%0d",
             tag, k, b, inj, s, d, n, o, run_cycles);
    chk({tag, " starts"}, s, es);
    chk({tag, " done_at"}, d, ed);
    chk({tag, " dones"}, n, 1);
    chk({tag, " overrun"}, o, eo);
    chk({tag, " grant_in_run"}, g, 0);
    chk({tag, " run_cycles"}, run_cycles, ec);
    chk({tag, " idle_after"}, host_busy, 1'b0);
  endtask

  typedef struct {
    int k;
    int b;
    int inj;
    int exp_starts;
    int exp_done;
    int exp_cycles;
    int exp_ovr;
  } vec_t;

  vec_t vecs [5];
  logic [WIDTH-1:0] rd;
  logic [ADDR_W-1:0] raddr [8];
  logic [WIDTH-1:0]  rdat  [8];
  logic [WIDTH-1:0]  ref_mem [0:2047];

  initial begin
    int es, ed, ec, eo, k, b, inj, bad;
    host_if.en = 1'b0; host_if.we = 1'b0; host_if.addr = '0; host_if.wdata = '0;
    eng_if.en  = 1'b0; eng_if.we  = 1'b0; eng_if.addr  = '0; eng_if.wdata  = '0;

    vecs[0] = '{0, 200, 0,  1, 203, 201, 0};   // basic handshake
    vecs[1] = '{3, 10,  0,  4, 16,  14,  0};   // late engine accept
    vecs[2] = '{0, 1,   0,  1, 4,   2,   0};   // shortest busy window
    vecs[3] = '{1, 5,   0,  2, 9,   7,   0};
    vecs[4] = '{0, 40,  20, 1, 43,  41,  1};   // host_start pulsed mid-RUN

    #1;
    chk("rst busy", host_busy, 1'b0);
    chk("rst done", host_done, 1'b0);
    chk("rst grant", host_grant, 1'b1);
    chk("rst eng_start", eng_start, 1'b0);
    chk("rst run_cycles", run_cycles, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++)
      check_run($sformatf("vec%0d", i), vecs[i].k, vecs[i].b, vecs[i].inj,
                vecs[i].exp_starts, vecs[i].exp_done, vecs[i].exp_cycles, vecs[i].exp_ovr);

    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 4);
      b = $urandom_range(1, 80);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3 + k + b) : 0;
      model(k, b, inj, es, ed, ec, eo);
      check_run($sformatf("rnd%0d", i), k, b, inj, es, ed, ec, eo);
    end

    // Random host traffic in IDLE against a reference memory
    for (int i = 0; i < 8; i++) begin
      raddr[i] = ADDR_W'($urandom_range(200, 699));
      rdat[i]  = WIDTH'($urandom);
      host_write(raddr[i], rdat[i]);
      ref_mem[raddr[i]] = rdat[i];
      $display("host write addr=%0d data=0x%04h", raddr[i], rdat[i]);
    end
    for (int i = 0; i < 8; i++) begin
      host_read(raddr[i], rd);
      $display("host read addr=%0d data=0x%04h", raddr[i], rd);
      chk($sformatf("mem rd%0d", i), rd, ref_mem[raddr[i]]);
    end

    // Arbitration: host write during RUN is dropped, engine access passes straight through
    host_write(11'd5, 16'h0055);
    cfg_k = 0; cfg_b = 30;
    @(negedge clk); host_start = 1'b1;
    @(negedge clk); host_start = 1'b0;
    repeat (3) @(negedge clk);
    host_if.en = 1'b1; host_if.we = 1'b1; host_if.addr = 11'd5;   host_if.wdata = 16'h1234;
    eng_if.en  = 1'b1; eng_if.we  = 1'b1; eng_if.addr  = 11'd100; eng_if.wdata  = 16'hBEEF;
    #1;
    chk("arb grant", host_grant, 1'b0);
    chk("arb mem_addr", mem_if.addr, 100);
    chk("arb mem_wdata", mem_if.wdata, 16'hBEEF);
    chk("arb mem_we", mem_if.we, 1'b1);
    @(negedge clk);
    host_if.en = 1'b0; host_if.we = 1'b0; eng_if.en = 1'b0; eng_if.we = 1'b0;
    for (int e = 0; e < 200 && !host_done; e++) @(negedge clk);
    chk("arb done seen", host_done, 1'b1);
    @(negedge clk);
    host_read(11'd5, rd);
    $display("arb read addr=5 data=0x%04h", rd);
    chk("arb host blocked", rd, 16'h0055);
    host_read(11'd100, rd);
    $display("arb read addr=100 data=0x%04h", rd);
    chk("arb eng write", rd, 16'hBEEF);
    host_write(11'd5, 16'h1234);
    host_read(11'd5, rd);
    chk("arb idle write", rd, 16'h1234);

    // Asynchronous reset in the middle of a long run
    cfg_k = 0; cfg_b = 500;
    @(negedge clk); host_start = 1'b1;
    @(negedge clk); host_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre-reset busy", host_busy, 1'b1);
    #2 reset = 1'b0;
    host_if.addr = 11'd7;
    #1;
    chk("mid rst busy", host_busy, 1'b0);
    chk("mid rst grant", host_grant, 1'b1);
    chk("mid rst run_cycles", run_cycles, 0);
    chk("mid rst done", host_done, 1'b0);
    chk("mid rst mem_addr", mem_if.addr, 7);
    @(negedge clk);
    reset = 1'b1;
    $display("reset applied mid-run");
    check_run("post_rst", 2, 6, 0, 3, 11, 9, 0);

`ifdef DESKEW_BYPASS_EN
    for (int i = 0; i < 784; i++) host_write(ADDR_W'(i), WIDTH'(i));
    host_bypass = 1'b1;
    begin
      int s, d, n, o, g;
      run_one(0, 1, 0, s, d, n, o, g);
      host_bypass = 1'b0;
      $display("run bypass: starts=%0d done_at=%0d dones=%0d run_cycles=%0d", s, d, n, run_cycles);
      chk("byp eng_start", s, 0);
      chk("byp done_at", d, 1569);
      chk("byp dones", n, 1);
      chk("byp run_cycles", run_cycles, 1568);
      chk("byp grant", g, 0);
    end
    bad = 0;
    for (int i = 0; i < 784; i++)
      if (bram[784 + i] !== WIDTH'(i)) bad++;
    chk("byp copy mismatches", bad, 0);
    bad = 0;
    for (int i = 0; i < 784; i++)
      if (bram[i] !== WIDTH'(i)) bad++;
    chk("byp raw intact", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
